// File: rtl/rgb_led_pwm_ctrl.sv
// Avalon-MM controlled PWM driver for NUM_LEDS RGB LEDs with frame-synchronous duty shadowing.
// Optional blink feature is compiled in with `define RGB_LED_PWM_BLINK_EN.
module rgb_led_pwm_ctrl #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 8,
  localparam int ADDR_W = $clog2(NUM_LEDS + 4)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic                  avs_write,
  input  logic                  avs_read,
  input  logic [31:0]           avs_writedata,
  output logic [31:0]           avs_readdata,
  output logic [3*NUM_LEDS-1:0] led_out
);

  localparam int DW = 3 * PWM_BITS;

  logic [1:0]            ctrl_q, ctrl_d;
  logic [15:0]           prescale_q, prescale_d;
  logic [15:0]           pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]         shadow_q [NUM_LEDS];
  logic [DW-1:0]         shadow_d [NUM_LEDS];
  logic [DW-1:0]         active_q [NUM_LEDS];
  logic [DW-1:0]         active_d [NUM_LEDS];
  logic [3*NUM_LEDS-1:0] raw;
  logic [3*NUM_LEDS-1:0] led_q, led_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           reg_rd;
  logic [31:0]           blink_rd;
  logic                  blink_phase;
  logic [NUM_LEDS-1:0]   blink_kill;
  logic                  en, tick, frame_end, prescale_wr;
  logic                  unused_wdata;

  assign unused_wdata = ^avs_writedata;

  assign en          = ctrl_q[0];
  assign prescale_wr = avs_write && (avs_address == ADDR_W'(1));
  assign tick        = en && (pre_cnt_q == prescale_q);
  assign frame_end   = tick && (pwm_cnt_q == '1);

  function automatic logic chan_on(input logic [PWM_BITS-1:0] duty,
                                   input logic [PWM_BITS-1:0] cnt);
    if (duty == '1) return 1'b1;
    if (duty == '0) return 1'b0;
    return cnt < duty;
  endfunction

  always_comb begin
    ctrl_d      = ctrl_q;
    prescale_d  = prescale_q;
    pre_cnt_d   = pre_cnt_q;
    pwm_cnt_d   = pwm_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (avs_write && (avs_address == ADDR_W'(0))) ctrl_d = avs_writedata[1:0];
    if (prescale_wr) prescale_d = avs_writedata[15:0];
    if (!en || prescale_wr || tick) pre_cnt_d = '0;
    else                            pre_cnt_d = pre_cnt_q + 16'd1;
    if (!en)       pwm_cnt_d = '0;
    else if (tick) pwm_cnt_d = pwm_cnt_q + 1'b1;
    if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  // Shadow takes the write this cycle, so a write on the boundary lands in the new frame.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (avs_write && (avs_address == ADDR_W'(i + 4))) shadow_d[i] = avs_writedata[DW-1:0];
      active_d[i] = frame_end ? shadow_d[i] : active_q[i];
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      for (int c = 0; c < 3; c++) begin
        raw[3*i+c] = en && !blink_kill[i] &&
                     chan_on(active_q[i][c*PWM_BITS +: PWM_BITS], pwm_cnt_q);
      end
    end
    led_d = raw ^ {3*NUM_LEDS{ctrl_q[1]}};
  end

  always_comb begin
    reg_rd = '0;
    if (avs_address == ADDR_W'(0))      reg_rd[1:0]  = ctrl_q;
    else if (avs_address == ADDR_W'(1)) reg_rd[15:0] = prescale_q;
    else if (avs_address == ADDR_W'(2)) reg_rd       = blink_rd;
    else if (avs_address == ADDR_W'(3)) reg_rd[16:0] = {blink_phase, frame_cnt_q};
    else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (avs_address == ADDR_W'(i + 4)) reg_rd[DW-1:0] = shadow_q[i];
      end
    end
    rdata_d = avs_read ? reg_rd : rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= '0;
      prescale_q  <= '0;
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      frame_cnt_q <= '0;
      led_q       <= '0;
      rdata_q     <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      led_q       <= led_d;
      rdata_q     <= rdata_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

`ifdef RGB_LED_PWM_BLINK_EN
  logic [15:0] blink_period_q, blink_period_d;
  logic [15:0] blink_mask_q, blink_mask_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic        unused_mask;

  assign unused_mask = ^blink_mask_q;
  assign blink_rd    = {blink_mask_q, blink_period_q};
  assign blink_phase = blink_phase_q;

  always_comb begin
    blink_period_d = blink_period_q;
    blink_mask_d   = blink_mask_q;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
    if (avs_write && (avs_address == ADDR_W'(2))) begin
      blink_period_d = avs_writedata[15:0];
      blink_mask_d   = avs_writedata[31:16];
    end
    // >= keeps a shortened period from running the counter all the way round.
    if (frame_end) begin
      if (blink_cnt_q >= blink_period_q) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
    for (int i = 0; i < NUM_LEDS; i++) blink_kill[i] = blink_phase_q && blink_mask_q[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_period_q <= '0;
      blink_mask_q   <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
    end else begin
      blink_period_q <= blink_period_d;
      blink_mask_q   <= blink_mask_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
    end
  end
`else
  assign blink_rd    = '0;
  assign blink_phase = 1'b0;
  assign blink_kill  = '0;
`endif

  assign avs_readdata = rdata_q;
  assign led_out      = led_q;

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// Directed bench for rgb_led_pwm_ctrl: register map, PWM duty, shadowing, invert/disable, reset.
module tb_rgb_led_pwm_ctrl;
  localparam int NL = 3;
  localparam int NB = 3 * NL;
`ifdef RGB_LED_PWM_BLINK_EN
  localparam logic [31:0] BLINK_EXP = 32'h0003_0005;
`else
  localparam logic [31:0] BLINK_EXP = 32'h0;
`endif

  logic          clk = 0;
  logic          reset_n = 0;
  logic [2:0]    avs_address = '0;
  logic          avs_write = 0;
  logic          avs_read = 0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic [NB-1:0] led_out;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int hc [NB];

  rgb_led_pwm_ctrl #(.NUM_LEDS(NL), .PWM_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_write(avs_write),
    .avs_read(avs_read), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .led_out(led_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    bit          wr;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    avs_address = a; avs_writedata = d; avs_write = 1;
    @(posedge clk); #1;
    avs_write = 0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    avs_address = a; avs_read = 1;
    @(posedge clk); #1;
    avs_read = 0;
    d = avs_readdata;
  endtask

  task automatic count_high(input int n);
    for (int b = 0; b < NB; b++) hc[b] = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      for (int b = 0; b < NB; b++) hc[b] += int'(led_out[b]);
    end
  endtask

  task automatic wait_red0(input logic lvl, input string name, output int cyc);
    cyc = -1;
    for (int k = 0; k < 1000 && cyc < 0; k++) begin
      @(posedge clk); #1;
      if (led_out[0] == lvl) cyc = cyc_cnt;
    end
    total++;
    if (cyc < 0) begin
      bad++;
      $display("FAIL %s: timeout waiting for red0=%0d", name, lvl);
    end
  endtask

  task automatic run_vec(input int i);
    logic [31:0] rd;
    if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata);
    do_read(vecs[i].addr, rd);
    check(vecs[i].name, rd, vecs[i].exp);
  endtask

  initial begin
    logic [31:0] rd;
    int c0, c1, c2, c3;

    vecs[0]  = '{3'd0, 32'h0, 1'b0, 32'h0, "rst_ctrl"};
    vecs[1]  = '{3'd1, 32'h0, 1'b0, 32'h0, "rst_prescale"};
    vecs[2]  = '{3'd2, 32'h0, 1'b0, 32'h0, "rst_blink"};
    vecs[3]  = '{3'd3, 32'h0, 1'b0, 32'h0, "rst_status"};
    vecs[4]  = '{3'd4, 32'h0, 1'b0, 32'h0, "rst_duty0"};
    vecs[5]  = '{3'd5, 32'h0, 1'b0, 32'h0, "rst_duty1"};
    vecs[6]  = '{3'd6, 32'h0, 1'b0, 32'h0, "rst_duty2"};
    vecs[7]  = '{3'd7, 32'h0, 1'b0, 32'h0, "rst_unmapped"};
    vecs[8]  = '{3'd1, 32'hABCD_1234, 1'b1, 32'h0000_1234, "wr_prescale"};
    vecs[9]  = '{3'd2, 32'h0003_0005, 1'b1, BLINK_EXP, "wr_blink"};
    vecs[10] = '{3'd3, 32'hFFFF_FFFF, 1'b1, 32'h0, "wr_status_ignored"};
    vecs[11] = '{3'd4, 32'hFF12_3456, 1'b1, 32'h0012_3456, "wr_duty0"};
    vecs[12] = '{3'd6, 32'h00FF_00FF, 1'b1, 32'h00FF_00FF, "wr_duty2"};
    vecs[13] = '{3'd7, 32'hFFFF_FFFF, 1'b1, 32'h0, "wr_unmapped"};
    vecs[14] = '{3'd0, 32'hFFFF_FFFC, 1'b1, 32'h0, "wr_ctrl_unused"};
    vecs[15] = '{3'd0, 32'h0000_0002, 1'b1, 32'h2, "wr_ctrl_invert"};
    vecs[16] = '{3'd0, 32'h0000_0000, 1'b1, 32'h0, "wr_ctrl_clear"};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_led_out", 32'(led_out), 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    reset_n = 1;
    for (int i = 0; i < 17; i++) run_vec(i);

    // Write and read to the same address in one cycle returns the old value
    @(posedge clk); #1;
    avs_address = 3'd1; avs_writedata = 32'h5555; avs_write = 1; avs_read = 1;
    @(posedge clk); #1;
    avs_write = 0; avs_read = 0;
    check("wr_rd_same_old", avs_readdata, 32'h1234);
    do_read(3'd1, rd);
    check("wr_rd_same_new", rd, 32'h5555);

    // Duty sweep and extremes over three frames
    do_write(3'd1, 32'h0);
    do_write(3'd2, 32'h0);
    do_write(3'd4, 32'h0000_0040);
    do_write(3'd5, 32'h00FF_00FF);
    do_write(3'd6, 32'h0);
    do_write(3'd0, 32'h1);
    repeat (300) @(posedge clk);
    count_high(768);
    check("sweep_red0", hc[0], 192);
    check("sweep_green0", hc[1], 0);
    check("sweep_blue0", hc[2], 0);
    check("ext_red1", hc[3], 768);
    check("ext_green1", hc[4], 0);
    check("ext_blue1", hc[5], 768);
    check("off_led2", hc[6] + hc[7] + hc[8], 0);

    // Shadowing: mid-frame duty write shows up only in the next frame
    wait_red0(1'b0, "sync_low", c0);
    wait_red0(1'b1, "rise0", c0);
    do_write(3'd4, 32'h0000_0080);
    wait_red0(1'b0, "fall0", c1);
    wait_red0(1'b1, "rise1", c2);
    wait_red0(1'b0, "fall1", c3);
    check("shadow_old_width", c1 - c0, 64);
    check("shadow_frame_len", c2 - c0, 256);
    check("shadow_new_width", c3 - c2, 128);

    // Reset asserted mid-frame
    repeat (20) @(posedge clk);
    #3 reset_n = 0;
    #1;
    check("midrst_led_out", 32'(led_out), 32'h0);
    check("midrst_readdata", avs_readdata, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    for (int i = 0; i < 8; i++) run_vec(i);
    repeat (5) @(posedge clk);
    #1;
    check("postrst_led_out", 32'(led_out), 32'h0);

    // Frame counting with PRESCALE=3 (1024-clock frames), then invert + disable
    do_write(3'd1, 32'h3);
    do_write(3'd0, 32'h1);
    repeat (2248) @(posedge clk);
    do_write(3'd0, 32'h0);
    do_read(3'd3, rd);
    check("status_frames", rd, 32'h2);
    do_write(3'd0, 32'h2);
    repeat (10) @(posedge clk);
    #1;
    check("invert_disabled", 32'(led_out), 32'h1FF);
    repeat (1100) @(posedge clk);
    do_read(3'd3, rd);
    check("status_frozen", rd, 32'h2);
    #1;
    check("invert_still", 32'(led_out), 32'h1FF);

`ifdef RGB_LED_PWM_BLINK_EN
    // Blink: LED0 off on alternate 2-frame periods, LED1 untouched
    do_write(3'd0, 32'h0);
    do_write(3'd1, 32'h0);
    do_write(3'd4, 32'h00FF_FFFF);
    do_write(3'd5, 32'h00FF_FFFF);
    do_write(3'd2, 32'h0001_0001);
    do_write(3'd0, 32'h1);
    repeat (600) @(posedge clk);
    count_high(1024);
    check("blink_red0", hc[0], 512);
    check("blink_red1", hc[3], 1024);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rgb_led_pwm_ctrl.md
RGB_LED_PWM_CTRL -- requirements
Module: rgb_led_pwm_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, giving the number of RGB LED channels (1..16).
REQ-002 SHALL have parameter PWM_BITS, default 8, giving the PWM resolution in bits (2..10).
REQ-003 SHALL derive ADDR_W = clog2(NUM_LEDS+4) as a localparam.
REQ-004 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port avs_address, input, ADDR_W bits: Avalon-MM word address.
REQ-007 SHALL have ports avs_write and avs_read, input, 1 bit each: Avalon-MM strobes.
REQ-008 SHALL have port avs_writedata, input, 32 bits: write data.
REQ-009 SHALL have port avs_readdata, output, 32 bits: read data.
REQ-010 SHALL have port led_out, output, 3*NUM_LEDS bits: bit 3i = red, 3i+1 = green, 3i+2 = blue of LED i.

Function
REQ-011 SHALL use this register map:
- 0x0 CTRL: bit0 = enable, bit1 = invert.
- 0x1 PRESCALE: [15:0].
- 0x2 BLINK: [15:0] = period, [31:16] = mask.
- 0x3 STATUS (read-only): [15:0] = frame count, [16] = blink phase.
- 0x4+i DUTY[i]: R = [P-1:0], G = [2P-1:P], B = [3P-1:2P], where P = PWM_BITS.
REQ-012 SHALL have read latency of exactly 1 clock: avs_readdata is registered in the cycle after avs_read is sampled high.
REQ-013 SHALL return 0 for unmapped addresses and for unused bits; writes to unmapped addresses and to STATUS SHALL be ignored.
REQ-014 SHALL give a write simultaneous with a read to the same address priority to the write; the read returns the old value.
REQ-015 SHALL have a prescaler that counts 0..PRESCALE and asserts a one-cycle tick when count equals PRESCALE, then returns to 0; PRESCALE = 0 gives a tick every clock.
REQ-016 SHALL have a PWM counter of PWM_BITS bits that increments on each tick and wraps from 2^P-1 to 0; the wrap tick marks a frame boundary.
REQ-017 SHALL load each DUTY write into a shadow register; the active duty SHALL update only at the frame boundary (glitch-free).
REQ-018 SHALL compute each colour output as (pwm_cnt < active_duty), except that an all-ones duty SHALL force the output constantly on and zero SHALL force it constantly off.
REQ-019 SHALL increment STATUS frame count at each frame boundary, wrapping from 0xFFFF to 0.
REQ-020 SHALL, when enable = 0, hold the prescaler and PWM counter at 0 and drive all raw outputs off.
REQ-021 SHALL XOR led_out with invert (when invert = 1, led_out = ~raw output), registered so that led_out is 1 clock after the compare.
REQ-022 SHALL restart the prescaler from 0 when PRESCALE is written mid-count; a DUTY write in the same cycle as a frame boundary SHALL take effect in that boundary.

Reset
REQ-023 SHALL, while reset_n is low, asynchronously clear all registers, counters, shadow and active duties, blink phase and avs_readdata to 0.
REQ-024 SHALL leave led_out = 0 after reset, because invert = 0.
REQ-025 SHALL, on reset asserted mid-frame, abort the frame; operation resumes from count 0 after release.

Configuration
REQ-026 SHALL use macro RGB_LED_PWM_BLINK_EN to select the blink feature.
REQ-027 SHALL, when RGB_LED_PWM_BLINK_EN is defined, toggle blink phase after every (period+1) frames; while phase = 1, LEDs whose mask bit is set SHALL have raw outputs forced off; period = 0 gives a toggle every frame.
REQ-028 SHALL, when RGB_LED_PWM_BLINK_EN is undefined, implement no blink logic, read BLINK as 0, ignore writes to it, and read STATUS[16] as 0.

Verification
REQ-029 SHALL cover duty sweep: PRESCALE = 0, enable = 1, DUTY[0] = 0x000040 -> red0 high 64 of 256 clocks per frame, green0/blue0 low.
REQ-030 SHALL cover extremes: DUTY[1] = 0xFF00FF -> red1 and blue1 constantly high, green1 constantly low across 3 frames.
REQ-031 SHALL cover shadowing: write DUTY[0] = 0x80 at count 10 -> the new duty is first seen at count 0 of the next frame.
REQ-032 SHALL cover invert and disable: invert = 1, enable = 0 -> all led_out bits = 1; STATUS frame count frozen.
REQ-033 SHALL cover blink (macro defined): BLINK = 0x0001_0001 -> LED0 forced off on alternate 2-frame periods, other LEDs unaffected; with macro undefined, BLINK reads 0x0.
REQ-034 SHALL cover reset: assert reset_n low mid-frame -> led_out = 0 and all registers read 0 after release.
